pdec_bank: RTL and testbench

Parametrised, pipelined multi-channel one-hot decoder bank, the sequential successor to the flat select-field decoders in the synthesis benchmark set. Requests carry a channel index, a select code and an enable. They are buffered in a small FIFO, decoded into a 2**SEL_W one-hot word in a registered output stage under valid/ready flow control, and the last decode per channel is held in a status register. It sits between a command source and per-channel load-enable fan-out.

---
 rtl/pdec_bank.sv | 176 +++++++++++++++++
 tb/tb_pdec_bank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdec_bank.sv
// pdec_bank: multi-channel one-hot decoder bank.
// Requests {ch, sel, en} are buffered in a DEPTH-entry FIFO, decoded into a
// 2**SEL_W one-hot word in a registered output stage under valid/ready flow
// control. The last completed decode of each channel is held in ch_state.
// Optional feature macro: PDEC_HIT_CNT_EN adds saturating per-channel hit
// counters. Without it, hit_cnt is tied to zero and cnt_clr is ignored.
module pdec_bank #(
    parameter  int SEL_W = 4,
    parameter  int N_CH  = 2,
    parameter  int DEPTH = 4,
    parameter  int HIT_W = 8,
    localparam int OH_W  = 1 << SEL_W,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH_W-1:0]        in_ch,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [OH_W-1:0]        out_onehot,
    output logic                   out_err,
    output logic [N_CH*OH_W-1:0]   ch_state,
    input  logic                   cnt_clr,
    output logic [N_CH*HIT_W-1:0]  hit_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [SEL_W-1:0] sel;
        logic             en;
    } req_t;

    // FIFO storage and bookkeeping
    req_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    // Output stage
    logic             r_out_valid;
    logic [CH_W-1:0]  r_out_ch;
    logic [OH_W-1:0]  r_out_oh;
    logic             r_out_err;

    // Per-channel last completed decode
    logic [OH_W-1:0]  r_ch_state [N_CH];

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_load;
    logic             w_done;
    logic             w_commit;
    req_t             w_head;
    logic             w_head_in_range;
    logic [OH_W-1:0]  w_head_oh;

    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A pop in the same cycle does not free a slot, so in_ready is purely
    // occupancy-derived and has no combinational path from out_ready.
    assign w_push   = in_valid && !w_full;
    assign w_load   = !w_empty && (!r_out_valid || out_ready);
    assign w_done   = r_out_valid && out_ready;
    assign w_commit = w_done && !r_out_err;

    assign w_head          = r_mem[r_rptr];
    assign w_head_in_range = (32'(w_head.ch) < N_CH);
    assign w_head_oh       = (w_head.en && w_head_in_range) ? (OH_W'(1) << w_head.sel) : '0;

    assign in_ready   = !w_full;
    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_onehot = r_out_oh;
    assign out_err    = r_out_err;

    // FIFO entry write on push
    // NOTE: the storage array has no reset; the pointers and occupancy
    // counter define which entries are live, so stale data is never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{ch: in_ch, sel: in_sel, en: in_en};
        end
    end

    // FIFO pointers and occupancy
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_load) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: load decoded head, drop valid on completion without reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_oh    <= '0;
            r_out_err   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_head.ch;
            r_out_oh    <= w_head_oh;
            r_out_err   <= !w_head_in_range;
        end else if (w_done) begin
            r_out_valid <= 1'b0;
        end
    end

    // Channel status: record the completed one-hot of an in-range result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) r_ch_state[c] <= '0;
        end else if (w_commit) begin
            for (int c = 0; c < N_CH; c++) begin
                if (32'(r_out_ch) == c) r_ch_state[c] <= r_out_oh;
            end
        end
    end

    // Flatten channel status onto the output bus
    // NOTE: every combinational output gets a default before the loop so no
    // path through the block can leave a bit unassigned and infer a latch.
    always_comb begin
        ch_state = '0;
        for (int c = 0; c < N_CH; c++) ch_state[c*OH_W +: OH_W] = r_ch_state[c];
    end

`ifdef PDEC_HIT_CNT_EN
    logic [HIT_W-1:0] r_hit [N_CH];

    // Saturating hit counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) r_hit[c] <= '0;
        end else if (cnt_clr) begin
            for (int c = 0; c < N_CH; c++) r_hit[c] <= '0;
        end else if (w_commit && (r_out_oh != '0)) begin
            for (int c = 0; c < N_CH; c++) begin
                if ((32'(r_out_ch) == c) && (r_hit[c] != '1)) r_hit[c] <= r_hit[c] + HIT_W'(1);
            end
        end
    end

    // Flatten hit counters onto the output bus
    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < N_CH; c++) hit_cnt[c*HIT_W +: HIT_W] = r_hit[c];
    end
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign hit_cnt          = '0;
`endif

endmodule

// File: tb/tb_pdec_bank.sv
// Self-checking bench for pdec_bank. A transaction-level reference model (a
// request queue plus one output slot) predicts every output each cycle.
// Built with N_CH=3 so channel code 3 is out of range, and HIT_W=2 so the
// optional hit counters saturate quickly.
module tb_pdec_bank;

    localparam int SEL_W   = 4;
    localparam int N_CH    = 3;
    localparam int DEPTH   = 4;
    localparam int HIT_W   = 2;
    localparam int OH_W    = 1 << SEL_W;
    localparam int CH_W    = 2;
    localparam int HIT_MAX = (1 << HIT_W) - 1;

    logic                  clk        = 1'b0;
    logic                  rst_n      = 1'b0;
    logic                  in_valid   = 1'b0;
    logic                  in_ready;
    logic [CH_W-1:0]       in_ch      = '0;
    logic [SEL_W-1:0]      in_sel     = '0;
    logic                  in_en      = 1'b0;
    logic                  out_valid;
    logic                  out_ready  = 1'b0;
    logic [CH_W-1:0]       out_ch;
    logic [OH_W-1:0]       out_onehot;
    logic                  out_err;
    logic [N_CH*OH_W-1:0]  ch_state;
    logic                  cnt_clr    = 1'b0;
    logic [N_CH*HIT_W-1:0] hit_cnt;

    pdec_bank #(
        .SEL_W (SEL_W),
        .N_CH  (N_CH),
        .DEPTH (DEPTH),
        .HIT_W (HIT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_sel     (in_sel),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .ch_state   (ch_state),
        .cnt_clr    (cnt_clr),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    typedef struct {
        int ch;
        int sel;
        bit en;
    } req_t;

    req_t m_q[$];
    bit   m_ov;
    int   m_ch;
    int   m_oh;
    bit   m_err;
    int   m_state [N_CH];
    int   m_hit   [N_CH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov  = 1'b0;
        m_ch  = 0;
        m_oh  = 0;
        m_err = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            m_state[c] = 0;
            m_hit[c]   = 0;
        end
    endtask

    // One clock edge of the reference: completion, counter update, load, push.
    task automatic model_edge(input bit v, input int ch, input int sel, input bit en,
                              input bit ordy, input bit clr, output bit pushed);
        bit   comp;
        bit   load;
        req_t r;
        comp   = m_ov && ordy;
        pushed = v && (m_q.size() < DEPTH);
        load   = (m_q.size() > 0) && (!m_ov || ordy);
        if (comp && !m_err) m_state[m_ch] = m_oh;
`ifdef PDEC_HIT_CNT_EN
        if (clr) begin
            for (int c = 0; c < N_CH; c++) m_hit[c] = 0;
        end else if (comp && !m_err && m_oh != 0 && m_hit[m_ch] < HIT_MAX) begin
            m_hit[m_ch] = m_hit[m_ch] + 1;
        end
`endif
        if (load) begin
            r     = m_q.pop_front();
            m_ov  = 1'b1;
            m_ch  = r.ch;
            m_err = (r.ch >= N_CH);
            m_oh  = (r.en && r.ch < N_CH) ? (1 << r.sel) : 0;
        end else if (comp) begin
            m_ov = 1'b0;
        end
        if (pushed) m_q.push_back('{ch: ch, sel: sel, en: en});
    endtask

    function automatic logic [N_CH*OH_W-1:0] exp_state();
        logic [N_CH*OH_W-1:0] e;
        e = '0;
        for (int c = 0; c < N_CH; c++) e[c*OH_W +: OH_W] = OH_W'(m_state[c]);
        return e;
    endfunction

    function automatic logic [N_CH*HIT_W-1:0] exp_hit();
        logic [N_CH*HIT_W-1:0] e;
        e = '0;
        for (int c = 0; c < N_CH; c++) e[c*HIT_W +: HIT_W] = HIT_W'(m_hit[c]);
        return e;
    endfunction

    // Drive inputs, check all outputs mid-cycle, then advance one edge.
    task automatic cycle(input bit v, input int ch, input int sel, input bit en,
                         input bit ordy, input bit clr, output bit pushed);
        in_valid  = v;
        in_ch     = CH_W'(ch);
        in_sel    = SEL_W'(sel);
        in_en     = en;
        out_ready = ordy;
        cnt_clr   = clr;
        @(negedge clk);
        check("in_ready", in_ready, m_q.size() < DEPTH);
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_ch", out_ch, m_ch);
            check("out_onehot", out_onehot, m_oh);
            check("out_err", out_err, m_err);
        end
        check("ch_state", ch_state, exp_state());
        check("hit_cnt", hit_cnt, exp_hit());
        @(posedge clk);
        model_edge(v, ch, sel, en, ordy, clr, pushed);
        #1;
    endtask

    task automatic send(input int ch, input int sel, input bit en, input bit ordy);
        bit pushed;
        int tries;
        pushed = 1'b0;
        tries  = 0;
        while (!pushed && tries < 20) begin
            cycle(1'b1, ch, sel, en, ordy, 1'b0, pushed);
            tries++;
        end
        if (!pushed) check("push_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        bit pushed;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, ordy, 1'b0, pushed);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_ch"}, out_ch, '0);
        check({tag, "_out_onehot"}, out_onehot, '0);
        check({tag, "_out_err"}, out_err, 1'b0);
        check({tag, "_ch_state"}, ch_state, '0);
        check({tag, "_hit_cnt"}, hit_cnt, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit   pushed;
        bit   pend;
        req_t pr;
        bit   ordy;
        bit   clr;
        int   hit_exp;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        reset_checks("rst");

        // Single request: ch=1 sel=5 en=1, result valid two edges after push
        send(1, 5, 1'b1, 1'b1);
        check("lat_not_yet", out_valid, 1'b0);
        idle(1, 1'b1);
        check("lat_valid", out_valid, 1'b1);
        check("lat_onehot", out_onehot, 16'h0020);
        idle(1, 1'b1);
        check("lat_state1", ch_state[OH_W +: OH_W], 16'h0020);
        check("lat_state0", ch_state[0 +: OH_W], 16'h0000);

        // Fill: five requests with out_ready low, sixth must be held
        for (int i = 0; i < 5; i++) send(0, i + 1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 0, 7, 1'b1, 1'b0, 1'b0, pushed);
            check("full_in_ready", in_ready, 1'b0);
            check("full_held", pushed, 1'b0);
        end
        send(0, 7, 1'b1, 1'b1);
        idle(8, 1'b1);
        check("drain_state0", ch_state[0 +: OH_W], 16'h0080);

        // Out-of-range channel, then an enable-low request on channel 0
        send(3, 2, 1'b1, 1'b1);
        idle(1, 1'b1);
        check("err_flag", out_err, 1'b1);
        check("err_onehot", out_onehot, 16'h0000);
        send(0, 0, 1'b0, 1'b1);
        check("err_state1", ch_state[OH_W +: OH_W], 16'h0020);
        idle(1, 1'b1);
        check("en0_err", out_err, 1'b0);
        idle(1, 1'b1);
        check("en0_state0", ch_state[0 +: OH_W], 16'h0000);

        // Stall with a pending result and a partly filled FIFO, then reset
        send(1, 9, 1'b1, 1'b0);
        idle(1, 1'b0);
        send(2, 3, 1'b1, 1'b0);
        send(2, 4, 1'b1, 1'b0);
        idle(3, 1'b0);
        check("stall_valid", out_valid, 1'b1);
        check("stall_onehot", out_onehot, 16'h0200);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("mid_rst");
        model_reset();
        #1 rst_n = 1'b1;
        idle(3, 1'b1);

        // Hit counters: five enabled completions on channel 0
        for (int i = 0; i < 5; i++) send(0, i, 1'b1, 1'b1);
        idle(3, 1'b1);
`ifdef PDEC_HIT_CNT_EN
        hit_exp = HIT_MAX;
`else
        hit_exp = 0;
`endif
        check("hit_sat", hit_cnt[0 +: HIT_W], HIT_W'(hit_exp));
        send(0, 4, 1'b1, 1'b0);
        idle(1, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, pushed);
        check("hit_clr", hit_cnt[0 +: HIT_W], '0);
        idle(1, 1'b1);

        // Randomised traffic with valid held until accepted
        pend = 1'b0;
        pr   = '{ch: 0, sel: 0, en: 1'b0};
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                pend = 1'b1;
                pr   = '{ch: int'($urandom_range(0, 3)), sel: int'($urandom_range(0, OH_W - 1)),
                         en: ($urandom_range(0, 4) != 0)};
            end
            ordy = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            cycle(pend, pr.ch, pr.sel, pr.en, ordy, clr, pushed);
            if (pushed) pend = 1'b0;
        end
        idle(8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
